bcd_seq_converter: RTL and testbench
====================================

BCD_SEQ_CONVERTER -- requirements
Module: bcd_seq_converter

Interface
REQ-001 SHALL have parameter WIDTH, default 9, meaning binary magnitude width; legal range 1..9.
REQ-002 SHALL have port clk, input, 1, single system clock; all state updates on rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port start, input, 1, conversion request; sampled on rising clk.
REQ-005 SHALL have port bin_in, input, WIDTH, unsigned magnitude from the add/sub stage.
REQ-006 SHALL have port neg_in, input, 1, sign of result; 1 = negative.
REQ-007 SHALL have port busy, output, 1, high while a conversion is in progress.
REQ-008 SHALL have port done, output, 1, one-cycle pulse when new digits are valid.
REQ-009 SHALL have ports bcd_hun, bcd_ten and bcd_uni, output, 4 each, hundreds, tens and units digits.
REQ-010 SHALL have port sign_out, output, 1, registered sign that accompanies the digits.

Function
REQ-011 SHALL implement FSM states IDLE, SHIFT and DONE, all registered.
REQ-012 In IDLE with start=1, SHALL capture bin_in and neg_in, clear the 12-bit BCD accumulator, load the bit counter with WIDTH, and go to SHIFT.
REQ-013 In IDLE with start=0, SHALL hold all outputs unchanged.
REQ-014 In SHIFT, each cycle SHALL add 3 to every BCD digit >= 5, then shift {accumulator, capture register} left by one bit, taking the capture register MSB into the units LSB.
REQ-015 SHALL decrement the bit counter once per SHIFT cycle and move to DONE after exactly WIDTH SHIFT cycles.
REQ-016 In DONE, SHALL copy the accumulator to bcd_hun/bcd_ten/bcd_uni, copy the captured sign to sign_out, assert done for exactly one cycle, and return to IDLE.
REQ-017 Latency: done SHALL be high in the cycle following the (WIDTH+1)-th rising edge after the edge that accepted start; for WIDTH=9 this is 10 edges.
REQ-018 busy SHALL be high in the SHIFT and DONE states and low in IDLE.
REQ-019 start in SHIFT or DONE SHALL be ignored and SHALL NOT be queued; bin_in and neg_in changes during a conversion SHALL NOT affect the result.
REQ-020 Digit outputs and sign_out SHALL hold their last converted values until the next DONE; they SHALL NOT show intermediate shift values.
REQ-021 A magnitude of 0 with neg_in=1 SHALL produce sign_out=1 unchanged; sign suppression is the display stage's job.
REQ-022 Every digit output SHALL be in the range 0..9 for all bin_in values; the maximum input of 511 SHALL produce 5,1,1.
REQ-023 start held high continuously SHALL start a new conversion on every return to IDLE, giving one conversion per WIDTH+2 cycles.

Reset
REQ-024 While reset=0, regardless of clk, SHALL force: state IDLE, busy=0, done=0, bcd_hun=bcd_ten=bcd_uni=0, sign_out=0, counter and shift registers cleared.
REQ-025 Reset asserted mid-conversion SHALL abort the conversion; done SHALL NOT pulse for the aborted request.
REQ-026 After reset is released, the first rising edge with start=1 SHALL be accepted normally.

Verification
REQ-027 bin_in=510, neg_in=0, start pulse -> after 10 edges done=1 for 1 cycle, digits 5,1,0, sign_out=0.
REQ-028 bin_in=205, neg_in=1 -> digits 2,0,5, sign_out=1; bin_in=0 -> digits 0,0,0; bin_in=255 -> digits 2,5,5.
REQ-029 Start with bin_in=105, then a second start pulse and bin_in change to 300 at cycle 4 -> result 1,0,5, exactly one done pulse, the second request dropped.
REQ-030 Start with bin_in=150, reset=0 at cycle 5 for 2 cycles -> outputs all 0, busy=0, no done pulse; the next start with 45 -> digits 0,4,5.
REQ-031 start held high with bin_in stepping 0..511 -> one done every 11 cycles, each result matching the decimal reference model.
REQ-032 Exhaustive sweep of all 512 bin_in values x neg_in -> digits equal bin_in/100, (bin_in/10)%10 and bin_in%10.

Source files
------------

// File: rtl/bcd_seq_converter.sv
// bcd_seq_converter: sequential double-dabble conversion of a WIDTH-bit magnitude to three BCD digits plus sign
module bcd_seq_converter #(
    parameter int WIDTH = 9
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] bin_in,
    input  logic             neg_in,
    output logic             busy,
    output logic             done,
    output logic [3:0]       bcd_hun,
    output logic [3:0]       bcd_ten,
    output logic [3:0]       bcd_uni,
    output logic             sign_out
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] sh;
    logic [11:0]      acc, adj;
    logic [WIDTH+11:0] nxt;
    logic [3:0]       cnt;
    logic             sign_cap;

    for (genvar i = 0; i < 3; i++) begin : g_adj
        assign adj[4*i +: 4] = acc[4*i +: 4] >= 4'd5 ? acc[4*i +: 4] + 4'd3 : acc[4*i +: 4];
    end

    // the capture register MSB feeds the units LSB on each shift
    assign nxt  = {adj, sh} << 1;
    assign busy = state != IDLE;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = start ? SHIFT : IDLE;
            SHIFT:   state_nx = cnt == 4'd1 ? DONE : SHIFT;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sh       <= '0;
            acc      <= '0;
            cnt      <= '0;
            sign_cap <= 1'b0;
            done     <= 1'b0;
            bcd_hun  <= '0;
            bcd_ten  <= '0;
            bcd_uni  <= '0;
            sign_out <= 1'b0;
        end else begin
            done <= state == DONE;
            if (state == IDLE && start) begin
                sh       <= bin_in;
                sign_cap <= neg_in;
                acc      <= '0;
                cnt      <= 4'(WIDTH);
            end else if (state == SHIFT) begin
                acc <= nxt[WIDTH+11:WIDTH];
                sh  <= nxt[WIDTH-1:0];
                cnt <= cnt - 4'd1;
            end else if (state == DONE) begin
                bcd_hun  <= acc[11:8];
                bcd_ten  <= acc[7:4];
                bcd_uni  <= acc[3:0];
                sign_out <= sign_cap;
            end
        end
    end

endmodule

// File: tb/tb_bcd_seq_converter.sv
// tb_bcd_seq_converter: vector table, corner sequences and streaming sweep with a done-driven scoreboard
module tb_bcd_seq_converter;

    typedef struct {
        logic [8:0] b;
        logic       n;
        logic [3:0] h, t, u;
    } vec_t;

    typedef struct {
        logic [3:0] h, t, u;
        logic       s;
    } exp_t;

    logic       clk, reset, start, neg_in;
    logic [8:0] bin_in;
    logic       busy, done, sign_out;
    logic [3:0] bcd_hun, bcd_ten, bcd_uni;

    int   n_chk, n_fail, done_cnt, d0;
    exp_t exp_q[$];
    bit   period_chk, prev_valid;
    time  last_t;

    bcd_seq_converter #(.WIDTH(9)) dut (
        .clk(clk), .reset(reset), .start(start), .bin_in(bin_in), .neg_in(neg_in),
        .busy(busy), .done(done), .bcd_hun(bcd_hun), .bcd_ten(bcd_ten),
        .bcd_uni(bcd_uni), .sign_out(sign_out)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t model(input int v, input logic n);
        exp_t e;
        e.h = 4'(v / 100);
        e.t = 4'((v / 10) % 10);
        e.u = 4'(v % 10);
        e.s = n;
        return e;
    endfunction

    always @(negedge clk) begin
        if (reset && done) begin
            done_cnt++;
            if (exp_q.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("digits_sign", {bcd_hun, bcd_ten, bcd_uni, sign_out}, {e.h, e.t, e.u, e.s});
            end
            if (period_chk) begin
                if (prev_valid) check("done_period", int'($time - last_t), 110);
                last_t     = $time;
                prev_valid = 1;
            end
        end
    end

    task automatic run_vec(input logic [8:0] b, input logic n, input logic [3:0] h, t, u);
        logic [12:0] prev;
        @(negedge clk);
        start  = 1;
        bin_in = b;
        neg_in = n;
        exp_q.push_back('{h, t, u, n});
        prev = {bcd_hun, bcd_ten, bcd_uni, sign_out};
        @(posedge clk);
        #1 start = 0;
        check("busy_after_accept", busy, 1);
        for (int k = 1; k <= 11; k++) begin
            @(posedge clk);
            #1;
            check("done_latency", done, k == 10);
            check("busy_window", busy, k < 10);
            if (k == 5) check("digits_hold", {bcd_hun, bcd_ten, bcd_uni, sign_out}, prev);
        end
    endtask

    initial begin
        vec_t tbl[6];
        tbl[0] = '{9'd510, 1'b0, 4'd5, 4'd1, 4'd0};
        tbl[1] = '{9'd205, 1'b1, 4'd2, 4'd0, 4'd5};
        tbl[2] = '{9'd0,   1'b0, 4'd0, 4'd0, 4'd0};
        tbl[3] = '{9'd255, 1'b0, 4'd2, 4'd5, 4'd5};
        tbl[4] = '{9'd511, 1'b0, 4'd5, 4'd1, 4'd1};
        tbl[5] = '{9'd0,   1'b1, 4'd0, 4'd0, 4'd0};
        n_chk = 0; n_fail = 0; done_cnt = 0;
        period_chk = 0; prev_valid = 0; last_t = 0;
        reset = 0; start = 0; bin_in = '0; neg_in = 0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", {busy, done, bcd_hun, bcd_ten, bcd_uni, sign_out}, 0);
        @(negedge clk) reset = 1;
        @(posedge clk);

        foreach (tbl[i]) run_vec(tbl[i].b, tbl[i].n, tbl[i].h, tbl[i].t, tbl[i].u);

        // second start and input change mid-conversion are dropped
        d0 = done_cnt;
        @(negedge clk);
        start = 1; bin_in = 9'd105; neg_in = 0;
        exp_q.push_back('{4'd1, 4'd0, 4'd5, 1'b0});
        @(posedge clk);
        #1 start = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        start = 1; bin_in = 9'd300; neg_in = 1;
        @(posedge clk);
        #1 start = 0;
        repeat (14) @(posedge clk);
        #1;
        check("single_done_on_overlap", done_cnt - d0, 1);
        check("queue_empty_overlap", exp_q.size(), 0);

        // asynchronous reset mid-conversion aborts without a done pulse
        d0 = done_cnt;
        @(negedge clk);
        start = 1; bin_in = 9'd150; neg_in = 1;
        @(posedge clk);
        #1 start = 0;
        repeat (4) @(posedge clk);
        #2 reset = 0;
        #1;
        check("async_reset_clear", {busy, done, bcd_hun, bcd_ten, bcd_uni, sign_out}, 0);
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1;
        repeat (14) @(posedge clk);
        #1;
        check("no_done_after_abort", done_cnt - d0, 0);
        check("idle_after_abort", {busy, bcd_hun, bcd_ten, bcd_uni, sign_out}, 0);
        run_vec(9'd45, 1'b0, 4'd0, 4'd4, 4'd5);

        // start held high: full sweep of both signs, one conversion per 11 cycles
        d0 = done_cnt;
        period_chk = 1;
        for (int n = 0; n < 2; n++) begin
            for (int v = 0; v < 512; v++) begin
                @(negedge clk);
                start  = 1;
                bin_in = 9'(v);
                neg_in = n[0];
                exp_q.push_back(model(v, n[0]));
                repeat (10) @(negedge clk);
            end
        end
        @(negedge clk) start = 0;
        repeat (14) @(posedge clk);
        #1;
        check("stream_done_count", done_cnt - d0, 1024);
        check("queue_empty_end", exp_q.size(), 0);
        check("idle_at_end", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
